// File: rtl/sqrt_resp_compactor.sv
// Compacts a run of sqrt result words into a 64-bit-style MISR signature and
// compares the final signature against a golden value.
module sqrt_resp_compactor #(
    parameter int                DATA_W = 64,
    parameter int                CNT_W  = 8,
    parameter logic [DATA_W-1:0] SEED   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_steps,
    input  logic [DATA_W-1:0] golden_sig,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] asqrt,
    output logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [DATA_W-1:0] signature,
    output logic [CNT_W-1:0]  samples_seen
);

    // Feedback taps for x^64 + x^4 + x^3 + x + 1.
    localparam logic [DATA_W-1:0] POLY = DATA_W'(64'h1B);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CHECK,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   num_q;
    logic               accept;
    logic               last_sample;
    logic [DATA_W-1:0]  sig_nxt;

    // The count guard keeps samples_seen from ever running past num_steps.
    assign sample_ready = (state == CAPTURE) && (samples_seen != num_q);
    assign busy         = (state == CAPTURE) || (state == CHECK);
    assign done         = (state == DONE);
    assign accept       = sample_valid && sample_ready;
    assign last_sample  = (samples_seen + CNT_W'(1)) == num_q;

    assign sig_nxt = {signature[DATA_W-2:0], 1'b0}
                   ^ (signature[DATA_W-1] ? POLY : '0)
                   ^ asqrt;

    // NOTE: state is held with non-blocking assignments so every flop samples
    // pre-edge values; the combinational block below uses blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_steps == '0) ? CHECK : CAPTURE;
                end
            end
            CAPTURE: begin
                if (accept && last_sample) begin
                    state_nxt = CHECK;
                end
            end
            CHECK:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Signature and count persist after DONE; only a new accepted start clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature    <= SEED;
            samples_seen <= '0;
            num_q        <= '0;
            pass         <= 1'b0;
        end else if (state == IDLE && start) begin
            signature    <= SEED;
            samples_seen <= '0;
            num_q        <= num_steps;
            pass         <= 1'b0;
        end else if (accept) begin
            signature    <= sig_nxt;
            samples_seen <= samples_seen + CNT_W'(1);
        end else if (state == CHECK) begin
            pass <= (signature == golden_sig);
        end
    end

endmodule

// File: tb/tb_sqrt_resp_compactor.sv
// Directed bench for sqrt_resp_compactor: a transaction-level model predicts
// every output each cycle, and literal expectations pin the model itself.
module tb_sqrt_resp_compactor;

    localparam int          DATA_W = 64;
    localparam int          CNT_W  = 8;
    localparam logic [63:0] SEED   = 64'h0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_steps = '0;
    logic [DATA_W-1:0] golden_sig = '0;
    logic              sample_valid = 1'b0;
    logic [DATA_W-1:0] asqrt = '0;
    logic              sample_ready;
    logic              busy;
    logic              done;
    logic              pass;
    logic [DATA_W-1:0] signature;
    logic [CNT_W-1:0]  samples_seen;

    int errors = 0;
    int checks = 0;

    sqrt_resp_compactor #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .SEED  (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_steps   (num_steps),
        .golden_sig  (golden_sig),
        .sample_valid(sample_valid),
        .asqrt       (asqrt),
        .sample_ready(sample_ready),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature),
        .samples_seen(samples_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Multiply by x in GF(2^64) modulo x^64+x^4+x^3+x+1, then add the new word.
    function automatic logic [63:0] misr_step(input logic [63:0] s, input logic [63:0] d);
        logic [63:0] r;
        r = s << 1;
        if (s[63]) r = r ^ 64'h1B;
        return r ^ d;
    endfunction

    // Transaction model: a run is open from accepted start until the last
    // sample; done falls two cycles after the closing event.
    int          cyc = 0;
    bit          m_run = 1'b0;
    logic [63:0] m_sig = SEED;
    int          m_seen = 0;
    int          m_n = 0;
    int          m_done_at = -10;
    bit          m_pass = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run     <= 1'b0;
            m_sig     <= SEED;
            m_seen    <= 0;
            m_n       <= 0;
            m_done_at <= -10;
            m_pass    <= 1'b0;
        end else begin
            if (!m_run && cyc > m_done_at && start) begin
                m_sig  <= SEED;
                m_seen <= 0;
                m_n    <= int'(num_steps);
                m_pass <= 1'b0;
                if (num_steps == 0) m_done_at <= cyc + 2;
                else                m_run     <= 1'b1;
            end else if (m_run && sample_valid) begin
                m_sig  <= misr_step(m_sig, asqrt);
                m_seen <= m_seen + 1;
                if (m_seen + 1 == m_n) begin
                    m_run     <= 1'b0;
                    m_done_at <= cyc + 2;
                end
            end else if (cyc == m_done_at - 1) begin
                m_pass <= (m_sig == golden_sig);
            end
        end
    end

    always @(negedge clk) begin
        check("done",         64'(done),         64'(cyc == m_done_at));
        check("busy",         64'(busy),         64'(m_run || cyc < m_done_at));
        check("sample_ready", 64'(sample_ready), 64'(m_run));
        check("pass",         64'(pass),         64'(m_pass));
        check("signature",    signature,         m_sig);
        check("samples_seen", 64'(samples_seen), 64'(m_seen));
    end

    int start_cyc;

    task automatic do_start(input int n, input logic [63:0] gold);
        start      = 1'b1;
        num_steps  = CNT_W'(n);
        golden_sig = gold;
        start_cyc  = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] d);
        sample_valid = 1'b1;
        asqrt        = d;
        @(negedge clk);
        sample_valid = 1'b0;
        asqrt        = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) check("done_timeout", 64'(done), 64'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(2);
        check("rst_busy",  64'(busy), 64'h0);
        check("rst_done",  64'(done), 64'h0);
        check("rst_sig",   signature, SEED);
        rst_n = 1'b1;
        idle(1);

        // One sample of 1, matching golden.
        do_start(1, 64'h1);
        send(64'h1);
        wait_done(10);
        check("t1_latency", 64'(cyc - start_cyc), 64'd3);
        check("t1_sig",     signature,            64'h1);
        check("t1_pass",    64'(pass),            64'h1);
        idle(1);

        // Two samples, mismatching golden.
        do_start(2, 64'h3);
        send(64'h1);
        send(64'h0);
        wait_done(10);
        check("t2_sig",  signature,          64'h2);
        check("t2_seen", 64'(samples_seen),  64'd2);
        check("t2_pass", 64'(pass),          64'h0);
        idle(1);

        // MSB shifted out exercises the feedback taps.
        do_start(2, 64'h1B);
        send(64'h8000_0000_0000_0000);
        send(64'h0);
        wait_done(10);
        check("t3_sig",  signature, 64'h1B);
        check("t3_pass", 64'(pass), 64'h1);
        idle(1);

        // Empty run, then stray samples while idle.
        do_start(0, SEED);
        wait_done(10);
        check("t4_latency", 64'(cyc - start_cyc), 64'd2);
        check("t4_sig",     signature,            SEED);
        check("t4_pass",    64'(pass),            64'h1);
        send(64'h5);
        send(64'h7);
        check("t4_seen_idle", 64'(samples_seen), 64'd0);
        check("t4_sig_idle",  signature,         SEED);

        // Gapped samples, a start ignored mid-run, a stray sample in CHECK.
        do_start(4, 64'h2);
        send(64'h1);
        idle(1);
        send(64'h2);
        do_start(1, 64'h2);
        send(64'h3);
        idle(2);
        check("t5_busy_mid", 64'(busy), 64'h1);
        send(64'h4);
        send(64'h9);
        wait_done(10);
        check("t5_seen", 64'(samples_seen), 64'd4);
        check("t5_sig",  signature,         64'h2);
        check("t5_pass", 64'(pass),         64'h1);
        idle(1);

        // Asynchronous reset in the middle of a run.
        do_start(4, 64'h0);
        send(64'h1);
        send(64'h2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  64'(busy),         64'h0);
        check("t6_rst_ready", 64'(sample_ready), 64'h0);
        check("t6_rst_sig",   signature,         SEED);
        check("t6_rst_seen",  64'(samples_seen), 64'd0);
        check("t6_rst_done",  64'(done),         64'h0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check("t6_no_done", 64'(done), 64'h0);
        do_start(1, 64'h1);
        send(64'h1);
        wait_done(10);
        check("t6_sig",  signature, 64'h1);
        check("t6_pass", 64'(pass), 64'h1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqrt_resp_compactor.md
SQRT_RESP_COMPACTOR -- requirements
Module: sqrt_resp_compactor

Interface
REQ-001 Parameter: DATA_W, default 64, width of the sqrt result word consumed per step.
REQ-002 Parameter: CNT_W, default 8, width of the step counter (max 2^CNT_W-1 samples per run).
REQ-003 Parameter: SEED, default 64'h0, initial signature value loaded on start.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
REQ-006 Port: start  input  1  one-cycle pulse that begins a run.
REQ-007 Port: num_steps  input  CNT_W  samples to compact in this run; sampled on accepted start.
REQ-008 Port: golden_sig  input  DATA_W  expected final signature; sampled on entry to CHECK.
REQ-009 Port: sample_valid  input  1  asqrt carries a settled sqrt result this cycle.
REQ-010 Port: asqrt  input  DATA_W  sqrt output word from the upstream sqrt netlist.
REQ-011 Port: sample_ready  output  1  high only in CAPTURE; a sample is accepted when sample_valid and sample_ready are both high.
REQ-012 Port: busy  output  1  high in CAPTURE and CHECK.
REQ-013 Port: done  output  1  one-cycle pulse on the cycle DONE is entered.
REQ-014 Port: pass  output  1  registered compare result, valid from done until the next accepted start.
REQ-015 Port: signature  output  DATA_W  current MISR contents.
REQ-016 Port: samples_seen  output  CNT_W  number of samples accepted this run.

Function
REQ-017 States SHALL be IDLE, CAPTURE, CHECK, DONE; DONE returns to IDLE on the next cycle.
REQ-018 start in IDLE SHALL load signature=SEED, samples_seen=0, latch num_steps, clear pass, and go to CAPTURE; if num_steps==0 go directly to CHECK.
REQ-019 start in any state other than IDLE SHALL be ignored.
REQ-020 Each accepted sample SHALL update signature to ({signature[DATA_W-2:0],1'b0} XOR (signature[DATA_W-1] ? 64'h1B : 0) XOR asqrt), i.e. polynomial x^64+x^4+x^3+x+1, and increment samples_seen, both in the same cycle.
REQ-021 When the accepted sample makes samples_seen equal the latched num_steps, the next state SHALL be CHECK.
REQ-022 sample_valid outside CAPTURE SHALL be ignored with no state change.
REQ-023 In CHECK (one cycle) pass SHALL be registered as (signature == golden_sig); next state DONE, done pulses for that one cycle.
REQ-024 Latency start-to-done SHALL be num_steps accepted samples + 2 cycles; with num_steps==0, exactly 2 cycles.
REQ-025 signature and samples_seen SHALL hold their values after DONE until the next accepted start.
REQ-026 samples_seen SHALL never wrap; no sample is accepted once the count reaches num_steps.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, signature=SEED, samples_seen=0, pass=0, done=0, busy=0, sample_ready=0, regardless of clock.
REQ-028 Reset asserted mid-run SHALL abandon the run without a done pulse; the first start after release begins a fresh run.

Verification
REQ-029 start, num_steps=1, sample asqrt=64'h1, golden_sig=64'h1 -> signature=64'h1, done pulse 3 cycles after start, pass=1.
REQ-030 num_steps=2, samples 64'h1 then 64'h0 -> signature=64'h2, samples_seen=2; golden_sig=64'h3 -> pass=0.
REQ-031 num_steps=2, samples 64'h8000_0000_0000_0000 then 64'h0 -> signature=64'h1B (feedback taps exercised).
REQ-032 num_steps=0, start -> done exactly 2 cycles later, signature=SEED; golden_sig=SEED -> pass=1; sample_valid pulses in IDLE leave samples_seen=0.
REQ-033 num_steps=4, sample_valid with gaps, second start during CAPTURE -> start ignored, done only after 4th accepted sample.
REQ-034 rst_n low after 2 of 4 samples -> all outputs at reset values asynchronously, no done; a new run with 1 sample of 64'h1 yields signature=64'h1.
